// File: rtl/serial_compare_arbiter.sv
// -----------------------------------------------------------------------------
// serial_compare_arbiter
//
// Shares one external 1-bit equality comparator among NREQ requesters. A
// requester is granted round-robin, its two WIDTH-bit operands are captured,
// and their bits are streamed MSB-first through the comparator. The first
// differing bit ends the comparison early; if no bit differs the operands
// are equal. The verdict is reported as eq/gt/lt (unsigned).
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   req      per-requester request, bit i = requester i
//   opa/opb  operand A/B per requester, slice i = op[i*WIDTH +: WIDTH]
//   gnt      one-hot grant, held through RUN and DONE
//   busy     high while RUN or DONE
//   cmp_a    bit presented to comparator input a (0 outside RUN)
//   cmp_b    bit presented to comparator input b (0 outside RUN)
//   cmp_res  comparator result (1 = bits equal), combinational from cmp_a/b
//   done     one-cycle completion pulse
//   done_id  index of the requester that completed
//   eq/gt/lt comparison verdict, held until the next completion
// -----------------------------------------------------------------------------
module serial_compare_arbiter #(
    parameter  int NREQ  = 2,
    parameter  int WIDTH = 8,
    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   opa,
    input  logic [NREQ*WIDTH-1:0]   opb,
    output logic [NREQ-1:0]         gnt,
    output logic                    busy,
    output logic                    cmp_a,
    output logic                    cmp_b,
    input  logic                    cmp_res,
    output logic                    done,
    output logic [IDW-1:0]          done_id,
    output logic                    eq,
    output logic                    gt,
    output logic                    lt
);

    localparam int             IW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0]  IDX_TOP  = IW'(WIDTH - 1);
    // Pointer starts at the last requester so the search begins at 0.
    localparam logic [IDW-1:0] PTR_RST  = IDW'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [IW-1:0]      idx_r;
    logic [IDW-1:0]     ptr_r;
    logic [IDW-1:0]     gid_r;
    logic [NREQ-1:0]    gnt_r;
    logic               done_r;
    logic [IDW-1:0]     done_id_r;
    logic               eq_r;
    logic               gt_r;
    logic               lt_r;
    logic               found_s;
    logic [IDW-1:0]     win_s;
    logic               last_bit_s;

    assign last_bit_s = (idx_r == {IW{1'b0}});

    // Round-robin winner: first requesting index after the pointer, with wrap.
    always_comb begin
        found_s = 1'b0;
        win_s   = {IDW{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            logic [IDW-1:0] cand_s;
            cand_s = IDW'((int'(ptr_r) + 1 + i) % NREQ);
            if (!found_s && req[cand_s]) begin
                found_s = 1'b1;
                win_s   = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; a comparator mismatch ends RUN early.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (found_s) state_nxt_s = ST_RUN;
                else         state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (!cmp_res || last_bit_s) state_nxt_s = ST_DONE;
                else                        state_nxt_s = ST_RUN;
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs: comparator bits come straight from the captured operands.
    always_comb begin
        busy  = (state_r != ST_IDLE);
        cmp_a = 1'b0;
        cmp_b = 1'b0;
        if (state_r == ST_RUN) begin
            cmp_a = a_r[idx_r];
            cmp_b = b_r[idx_r];
        end else begin
            cmp_a = 1'b0;
            cmp_b = 1'b0;
        end
    end

    // Datapath: operand capture, bit walk, verdict and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r       <= {WIDTH{1'b0}};
            b_r       <= {WIDTH{1'b0}};
            idx_r     <= IDX_TOP;
            ptr_r     <= PTR_RST;
            gid_r     <= {IDW{1'b0}};
            gnt_r     <= {NREQ{1'b0}};
            done_r    <= 1'b0;
            done_id_r <= {IDW{1'b0}};
            eq_r      <= 1'b0;
            gt_r      <= 1'b0;
            lt_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (found_s) begin
                        a_r   <= opa[int'(win_s)*WIDTH +: WIDTH];
                        b_r   <= opb[int'(win_s)*WIDTH +: WIDTH];
                        gid_r <= win_s;
                        gnt_r <= {{(NREQ-1){1'b0}}, 1'b1} << win_s;
                        idx_r <= IDX_TOP;
                    end else begin
                        gnt_r <= {NREQ{1'b0}};
                    end
                end
                ST_RUN: begin
                    if (!cmp_res) begin
                        // First differing bit decides: A has the 1 means A > B.
                        eq_r      <= 1'b0;
                        gt_r      <= a_r[idx_r];
                        lt_r      <= ~a_r[idx_r];
                        done_r    <= 1'b1;
                        done_id_r <= gid_r;
                    end else if (last_bit_s) begin
                        eq_r      <= 1'b1;
                        gt_r      <= 1'b0;
                        lt_r      <= 1'b0;
                        done_r    <= 1'b1;
                        done_id_r <= gid_r;
                    end else begin
                        idx_r <= idx_r - IW'(1);
                    end
                end
                ST_DONE: begin
                    done_r <= 1'b0;
                    gnt_r  <= {NREQ{1'b0}};
                    ptr_r  <= gid_r;
                    idx_r  <= IDX_TOP;
                end
                default: begin
                    done_r <= 1'b0;
                    gnt_r  <= {NREQ{1'b0}};
                end
            endcase
        end
    end

    assign gnt     = gnt_r;
    assign done    = done_r;
    assign done_id = done_id_r;
    assign eq      = eq_r;
    assign gt      = gt_r;
    assign lt      = lt_r;

endmodule
